// File: rtl/st_frame_buffer.sv
// st_frame_buffer: frames the self-trigger fclk word stream (din/kin) on
// SOF/EOF K-characters, stores only complete frames in a word FIFO, and
// replays them on a valid/ready stream with tlast. Frames are written
// speculatively and become visible only when EOF commits them; truncated,
// oversized or overflowing frames are rewound and counted as drops.
// Optional feature: define ST_FRAME_BUF_HWM_EN to add the fifo_hwm port
// (highest fifo_level seen since reset).
module st_frame_buffer #(
  parameter int         ADDR_W          = 10,
  parameter int         MAX_FRAME_WORDS = 512,
  parameter logic [7:0] SOF_CHAR        = 8'h3C,
  parameter logic [7:0] EOF_CHAR        = 8'hDC,
  parameter logic [7:0] IDLE_CHAR       = 8'hBC
) (
  input  logic              fclk,
  input  logic              reset_fclk,
  input  logic [31:0]       din,
  input  logic [3:0]        kin,
  input  logic              enable,
  output logic [31:0]       m_tdata,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [31:0]       frame_count,
  output logic [15:0]       drop_count,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow
`ifdef ST_FRAME_BUF_HWM_EN
  ,
  output logic [ADDR_W:0]   fifo_hwm
`endif
);

  localparam int            PW      = ADDR_W + 1;
  localparam int            DEPTH   = 1 << ADDR_W;
  localparam logic [PW-1:0] MAX_CNT = PW'(MAX_FRAME_WORDS);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DROP    = 2'd2;

  // Drop counter sticks at its maximum instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Pointers carry one extra wrap bit: equal low bits with differing MSB means full.
  function automatic logic ptr_full(input logic [PW-1:0] w, input logic [PW-1:0] r);
    return (w[ADDR_W] != r[ADDR_W]) && (w[ADDR_W-1:0] == r[ADDR_W-1:0]);
  endfunction

  // Word storage: {last, data}
  logic [32:0] mem [0:DEPTH-1];

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;   // speculative write position
  logic [PW-1:0] cm_ptr_q, cm_ptr_d;   // end of the last committed frame
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;   // words handed to the consumer
  logic [PW-1:0] fe_ptr_q, fe_ptr_d;   // words fetched into the output register
  logic [PW-1:0] cnt_q, cnt_d;         // payload words in the current frame
  logic [31:0]   last_data_q, last_data_d;
  logic [31:0]   frame_count_q, frame_count_d;
  logic [15:0]   drop_count_q, drop_count_d;
  logic          overflow_q, overflow_d;
  logic [PW-1:0] level_q, level_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic [31:0]   tdata_q, tdata_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [32:0]       mem_wdata;
  logic [32:0]       fe_word;
  logic [PW-1:0]     wr_prev;

  logic k_ctl, w_sof, w_eof, w_idle, w_data, w_badk;

  assign k_ctl   = (kin == 4'b0001);
  assign w_sof   = k_ctl && (din[7:0] == SOF_CHAR);
  assign w_eof   = k_ctl && (din[7:0] == EOF_CHAR);
  assign w_idle  = k_ctl && (din[7:0] == IDLE_CHAR);
  assign w_data  = (kin == 4'b0000);
  assign w_badk  = !(w_sof || w_eof || w_idle || w_data);
  assign wr_prev = wr_ptr_q - PW'(1);

  // Frame delimiting FSM: speculative writes, commit on EOF, rewind on abort.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    cm_ptr_d      = cm_ptr_q;
    cnt_d         = cnt_q;
    last_data_d   = last_data_q;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    overflow_d    = overflow_q;
    mem_we        = 1'b0;
    mem_waddr     = wr_ptr_q[ADDR_W-1:0];
    mem_wdata     = {1'b0, din};
    case (state_q)
      S_IDLE: begin
        if (w_sof && enable) begin
          state_d  = S_CAPTURE;
          wr_ptr_d = cm_ptr_q;
          cnt_d    = '0;
        end
      end
      S_CAPTURE: begin
        if (w_data) begin
          if (ptr_full(wr_ptr_q, rd_ptr_q)) begin
            state_d      = S_DROP;
            wr_ptr_d     = cm_ptr_q;
            overflow_d   = 1'b1;
            drop_count_d = sat_inc16(drop_count_q);
          end else if (cnt_q == MAX_CNT) begin
            state_d      = S_DROP;
            wr_ptr_d     = cm_ptr_q;
            drop_count_d = sat_inc16(drop_count_q);
          end else begin
            mem_we      = 1'b1;
            wr_ptr_d    = wr_ptr_q + PW'(1);
            cnt_d       = cnt_q + PW'(1);
            last_data_d = din;
          end
        end else if (w_eof) begin
          if (cnt_q != '0) begin
            // Re-write the final word with its last flag, then publish the frame.
            mem_we        = 1'b1;
            mem_waddr     = wr_prev[ADDR_W-1:0];
            mem_wdata     = {1'b1, last_data_q};
            cm_ptr_d      = wr_ptr_q;
            frame_count_d = frame_count_q + 32'd1;
          end
          state_d = S_IDLE;
        end else if (w_sof) begin
          // Restart: the truncated frame is discarded, capture begins afresh.
          wr_ptr_d     = cm_ptr_q;
          cnt_d        = '0;
          drop_count_d = sat_inc16(drop_count_q);
        end else if (w_badk) begin
          wr_ptr_d     = cm_ptr_q;
          drop_count_d = sat_inc16(drop_count_q);
          state_d      = S_IDLE;
        end
      end
      S_DROP: begin
        if (w_eof) begin
          state_d = S_IDLE;
        end else if (w_sof && enable) begin
          state_d  = S_CAPTURE;
          wr_ptr_d = cm_ptr_q;
          cnt_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output register: fetch the next committed word whenever the slot is free or draining.
  always_comb begin
    fe_word  = mem[fe_ptr_q[ADDR_W-1:0]];
    fe_ptr_d = fe_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    if (tvalid_q && m_tready) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if ((!tvalid_q || m_tready) && (fe_ptr_q != cm_ptr_q)) begin
      tvalid_d = 1'b1;
      tdata_d  = fe_word[31:0];
      tlast_d  = fe_word[32];
      fe_ptr_d = fe_ptr_q + PW'(1);
    end else if (tvalid_q && m_tready) begin
      tvalid_d = 1'b0;
    end
    level_d = cm_ptr_d - rd_ptr_d;
  end

  // FIFO storage write port (no reset on the array contents).
  always_ff @(posedge fclk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge fclk or posedge reset_fclk) begin
    if (reset_fclk) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      cm_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fe_ptr_q      <= '0;
      cnt_q         <= '0;
      last_data_q   <= '0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
      overflow_q    <= 1'b0;
      level_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      cm_ptr_q      <= cm_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fe_ptr_q      <= fe_ptr_d;
      cnt_q         <= cnt_d;
      last_data_q   <= last_data_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      overflow_q    <= overflow_d;
      level_q       <= level_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tdata_q       <= tdata_d;
    end
  end

`ifdef ST_FRAME_BUF_HWM_EN
  logic [PW-1:0] hwm_q, hwm_d;

  // Track the largest registered fill level seen since reset.
  always_comb begin
    hwm_d = (level_q > hwm_q) ? level_q : hwm_q;
  end

  // High-water-mark register.
  always_ff @(posedge fclk or posedge reset_fclk) begin
    if (reset_fclk) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign fifo_hwm = hwm_q;
`endif

  assign m_tdata     = tdata_q;
  assign m_tlast     = tlast_q;
  assign m_tvalid    = tvalid_q;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
  assign fifo_level  = level_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_st_frame_buffer.sv
// Bench for st_frame_buffer: directed frame sequences, a table of
// single-word disturbances inside a frame, and a randomized stream checked
// against a queue-based frame model.
`timescale 1ns/1ps
module tb_st_frame_buffer;
  localparam int         AW   = 4;
  localparam int         MAXW = 8;
  localparam logic [7:0] SOFC = 8'h3C;
  localparam logic [7:0] EOFC = 8'hDC;
  localparam logic [7:0] IDLC = 8'hBC;

  logic        fclk = 1'b0;
  logic        reset_fclk = 1'b0;
  logic [31:0] din = {24'h0, IDLC};
  logic [3:0]  kin = 4'b0001;
  logic        enable = 1'b1;
  logic        m_tready = 1'b1;

  // main instance: 16-word FIFO, 8-word frame limit
  logic [31:0] d_tdata, d_fc;
  logic        d_tlast, d_tvalid, d_ovf;
  logic [15:0] d_dc;
  logic [AW:0] d_lvl;
  // second instance: 16-word FIFO, 16-word frame limit (overflow scenario)
  logic [31:0] o_tdata, o_fc;
  logic        o_tlast, o_tvalid, o_ovf;
  logic [15:0] o_dc;
  logic [AW:0] o_lvl;
`ifdef ST_FRAME_BUF_HWM_EN
  logic [AW:0] d_hwm, o_hwm;
`endif

  st_frame_buffer #(.ADDR_W(AW), .MAX_FRAME_WORDS(MAXW)) u_dut (
    .fclk(fclk), .reset_fclk(reset_fclk), .din(din), .kin(kin), .enable(enable),
    .m_tdata(d_tdata), .m_tlast(d_tlast), .m_tvalid(d_tvalid), .m_tready(m_tready),
    .frame_count(d_fc), .drop_count(d_dc), .fifo_level(d_lvl), .overflow(d_ovf)
`ifdef ST_FRAME_BUF_HWM_EN
    , .fifo_hwm(d_hwm)
`endif
  );

  st_frame_buffer #(.ADDR_W(AW), .MAX_FRAME_WORDS(16)) u_ovf (
    .fclk(fclk), .reset_fclk(reset_fclk), .din(din), .kin(kin), .enable(enable),
    .m_tdata(o_tdata), .m_tlast(o_tlast), .m_tvalid(o_tvalid), .m_tready(m_tready),
    .frame_count(o_fc), .drop_count(o_dc), .fifo_level(o_lvl), .overflow(o_ovf)
`ifdef ST_FRAME_BUF_HWM_EN
    , .fifo_hwm(o_hwm)
`endif
  );

  always #5 fclk = ~fclk;

  int total = 0;
  int bad = 0;
  logic rnd_rdy = 1'b0;

  logic [32:0] mon_q[$];
  logic [32:0] omon_q[$];
  logic [32:0] mdl_q[$];
  logic [32:0] want_q[$];

  // Record every completed transfer ({last,data}); sampled mid-cycle.
  always @(negedge fclk) begin
    if (!reset_fclk && d_tvalid && m_tready) mon_q.push_back({d_tlast, d_tdata});
    if (!reset_fclk && o_tvalid && m_tready) omon_q.push_back({o_tlast, o_tdata});
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (u_dut configuration) ----------------
  int          m_mode;      // 0 waiting for SOF, 1 collecting, 2 discarding to EOF
  logic [31:0] m_frame[$];
  int          m_frames;
  int          m_drops;

  task automatic model_word(input logic [3:0] k, input logic [31:0] d, input logic en);
    int cls; // 0 data, 1 sof, 2 eof, 3 idle, 4 bad
    if (k == 4'b0000) cls = 0;
    else if (k == 4'b0001 && d[7:0] == SOFC) cls = 1;
    else if (k == 4'b0001 && d[7:0] == EOFC) cls = 2;
    else if (k == 4'b0001 && d[7:0] == IDLC) cls = 3;
    else cls = 4;
    if (m_mode == 0) begin
      if (cls == 1 && en) begin m_mode = 1; m_frame.delete(); end
    end else if (m_mode == 1) begin
      if (cls == 0) begin
        if (m_frame.size() == MAXW) begin m_mode = 2; m_drops++; end
        else m_frame.push_back(d);
      end else if (cls == 1) begin
        m_frame.delete(); m_drops++;
      end else if (cls == 2) begin
        for (int i = 0; i < m_frame.size(); i++)
          mdl_q.push_back({(i == m_frame.size() - 1), m_frame[i]});
        if (m_frame.size() > 0) m_frames++;
        m_mode = 0;
      end else if (cls == 4) begin
        m_drops++; m_mode = 0;
      end
    end else begin
      if (cls == 2) m_mode = 0;
      else if (cls == 1 && en) begin m_mode = 1; m_frame.delete(); end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [3:0] k, input logic [31:0] d);
    kin = k;
    din = d;
    if (rnd_rdy) m_tready = ($urandom_range(0, 3) != 0);
    model_word(k, d, enable);
    @(posedge fclk); #1;
  endtask

  task automatic sofw();  send(4'b0001, {24'h0, SOFC}); endtask
  task automatic eofw();  send(4'b0001, {24'h0, EOFC}); endtask
  task automatic idlew(); send(4'b0001, {24'h0, IDLC}); endtask
  task automatic dataw(input logic [31:0] d); send(4'b0000, d); endtask
  task automatic idles(input int n); repeat (n) idlew(); endtask

  task automatic do_reset();
    reset_fclk = 1'b1;
    kin = 4'b0001;
    din = {24'h0, IDLC};
    @(posedge fclk); #1;
    reset_fclk = 1'b0;
    @(posedge fclk); #1;
    mon_q.delete(); omon_q.delete(); mdl_q.delete(); want_q.delete();
    m_mode = 0; m_frame.delete(); m_frames = 0; m_drops = 0;
  endtask

  // Compare captured output words of u_dut against want_q.
  task automatic cmp_want(input string nm);
    chk({nm, "_len"}, mon_q.size(), want_q.size());
    for (int i = 0; i < want_q.size() && i < mon_q.size(); i++)
      chk($sformatf("%s_w%0d", nm, i), mon_q[i], want_q[i]);
  endtask

  task automatic drain(input string nm, input int maxc);
    int n = 0;
    while ((d_lvl != 0 || d_tvalid) && n < maxc) begin idlew(); n++; end
    chk({nm, "_drained"}, (d_lvl == 0 && !d_tvalid), 1);
    idlew();
  endtask

  // ---------------- table of single disturbances inside a frame ----------------
  typedef struct {
    logic [3:0]  k;
    logic [31:0] d;
    int          frames;
    int          drops;
    int          words;
    logic [32:0] lastw;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int fc0, dc0, len, r;
    logic [31:0] rv;

    tbl[0] = '{4'b0000, 32'h0000_5A5A, 1, 0, 3, 33'h1_2222_0000}; // plain DATA
    tbl[1] = '{4'b0001, 32'h0000_00BC, 1, 0, 2, 33'h1_2222_0000}; // IDLE ignored
    tbl[2] = '{4'b0001, 32'h0000_001C, 0, 1, 0, 33'h0};           // unknown K byte
    tbl[3] = '{4'b0010, 32'h0000_3C00, 0, 1, 0, 33'h0};           // K on wrong lane
    tbl[4] = '{4'b1111, 32'hDCDC_DCDC, 0, 1, 0, 33'h0};           // all-K word
    tbl[5] = '{4'b0001, 32'h0000_003C, 1, 1, 1, 33'h1_2222_0000}; // SOF restarts
    tbl[6] = '{4'b0001, 32'h0000_00DC, 1, 0, 1, 33'h1_1111_0000}; // early EOF
    tbl[7] = '{4'b0001, 32'hFFFF_FF3C, 1, 1, 1, 33'h1_2222_0000}; // only byte 0 decides
    tbl[8] = '{4'b0000, 32'h0000_00DC, 1, 0, 3, 33'h1_2222_0000}; // EOF byte as data

    // reset state
    reset_fclk = 1'b1;
    #2;
    chk("rst_tvalid", d_tvalid, 0);
    chk("rst_tlast", d_tlast, 0);
    chk("rst_tdata", d_tdata, 0);
    chk("rst_fc", d_fc, 0);
    chk("rst_dc", d_dc, 0);
    chk("rst_lvl", d_lvl, 0);
    chk("rst_ovf", d_ovf, 0);
    chk("rst_o_lvl", o_lvl, 0);
    @(posedge fclk); #1;
    do_reset();

    // basic frame and commit latency
    m_tready = 1'b1;
    sofw();
    dataw(32'h11); dataw(32'h22); dataw(32'h33); dataw(32'h44);
    eofw();
    chk("lat_eof_plus1_tvalid", d_tvalid, 0);
    idlew();
    chk("lat_eof_plus2_tvalid", d_tvalid, 1);
    chk("lat_eof_plus2_tdata", d_tdata, 32'h11);
    idles(6);
    want_q = '{33'h0_0000_0011, 33'h0_0000_0022, 33'h0_0000_0033, 33'h1_0000_0044};
    cmp_want("basic");
    chk("basic_fc", d_fc, 1);

    // SOF inside a frame discards the partial one
    do_reset();
    sofw(); dataw(32'h1); dataw(32'h2); dataw(32'h3);
    sofw(); dataw(32'hA); dataw(32'hB); eofw();
    idles(6);
    want_q = '{33'h0_0000_000A, 33'h1_0000_000B};
    cmp_want("resof");
    chk("resof_dc", d_dc, 1);
    chk("resof_fc", d_fc, 1);

    // FIFO overflow on the 16-word-frame instance
    do_reset();
    m_tready = 1'b0;
    sofw(); for (int i = 0; i < 10; i++) dataw(32'h300 + i); eofw();
    sofw(); for (int i = 0; i < 10; i++) dataw(32'h400 + i); eofw();
    idles(3);
    chk("ovf_lvl", o_lvl, 10);
    chk("ovf_flag", o_ovf, 1);
    chk("ovf_dc", o_dc, 1);
    chk("ovf_fc", o_fc, 1);
    m_tready = 1'b1;
    idles(16);
    chk("ovf_read_len", omon_q.size(), 10);
    if (omon_q.size() == 10) begin
      chk("ovf_first", omon_q[0], 33'h0_0000_0300);
      chk("ovf_last", omon_q[9], 33'h1_0000_0309);
    end
    chk("ovf_lvl_empty", o_lvl, 0);
    chk("ovf_sticky", o_ovf, 1);

    // frame length limit: 8 accepted, 9 dropped, next frame intact
    do_reset();
    sofw(); for (int i = 0; i < 8; i++) dataw(32'h500 + i); eofw();
    sofw(); for (int i = 0; i < 9; i++) dataw(32'h600 + i); eofw();
    sofw(); dataw(32'h6A); dataw(32'h6B); eofw();
    idles(14);
    chk("max_len", mon_q.size(), 10);
    if (mon_q.size() == 10) begin
      chk("max_full_last", mon_q[7], 33'h1_0000_0507);
      chk("max_next0", mon_q[8], 33'h0_0000_006A);
      chk("max_next1", mon_q[9], 33'h1_0000_006B);
    end
    chk("max_dc", d_dc, 1);
    chk("max_fc", d_fc, 2);
    chk("max_ovf", d_ovf, 0);

    // empty frame and interleaved IDLE words
    do_reset();
    sofw(); eofw();
    sofw(); dataw(32'hD1); idlew(); dataw(32'hD2); idlew(); idlew(); dataw(32'hD3); eofw();
    idles(6);
    want_q = '{33'h0_0000_00D1, 33'h0_0000_00D2, 33'h1_0000_00D3};
    cmp_want("idle");
    chk("idle_fc", d_fc, 1);
    chk("idle_dc", d_dc, 0);

    // enable handling
    do_reset();
    enable = 1'b0;
    sofw(); dataw(32'h70); eofw();
    enable = 1'b1;
    sofw(); dataw(32'h71); enable = 1'b0; dataw(32'h72); eofw();
    enable = 1'b1;
    sofw(); dataw(32'h81); enable = 1'b0; sofw(); dataw(32'h82); eofw();
    enable = 1'b1;
    idles(6);
    want_q = '{33'h0_0000_0071, 33'h1_0000_0072, 33'h1_0000_0082};
    cmp_want("en");
    chk("en_fc", d_fc, 2);
    chk("en_dc", d_dc, 1);

    // asynchronous reset while words are pending
    do_reset();
    m_tready = 1'b0;
    sofw(); for (int i = 0; i < 5; i++) dataw(32'h900 + i); eofw();
    idles(3);
    chk("arst_pre_lvl", d_lvl, 5);
    chk("arst_pre_tvalid", d_tvalid, 1);
    #2 reset_fclk = 1'b1;
    #1;
    chk("arst_tvalid", d_tvalid, 0);
    chk("arst_lvl", d_lvl, 0);
    chk("arst_fc", d_fc, 0);
    chk("arst_tdata", d_tdata, 0);
    @(posedge fclk); #1;
    reset_fclk = 1'b0;
    mon_q.delete();
    m_mode = 0; m_frame.delete(); mdl_q.delete(); m_frames = 0; m_drops = 0;
    m_tready = 1'b1;
    sofw(); dataw(32'hE1); dataw(32'hE2); eofw();
    idles(6);
    want_q = '{33'h0_0000_00E1, 33'h1_0000_00E2};
    cmp_want("arst_next");
    chk("arst_next_fc", d_fc, 1);

    // table-driven disturbances
    do_reset();
    foreach (tbl[v]) begin
      fc0 = d_fc;
      dc0 = d_dc;
      mon_q.delete();
      sofw(); dataw(32'h1111_0000); send(tbl[v].k, tbl[v].d); dataw(32'h2222_0000); eofw();
      idles(8);
      chk($sformatf("tbl%0d_fc", v), d_fc - fc0, tbl[v].frames);
      chk($sformatf("tbl%0d_dc", v), d_dc - dc0, tbl[v].drops);
      chk($sformatf("tbl%0d_words", v), mon_q.size(), tbl[v].words);
      if (tbl[v].words > 0 && mon_q.size() > 0)
        chk($sformatf("tbl%0d_last", v), mon_q[$], tbl[v].lastw);
    end

    // randomized stream against the model
    do_reset();
    rnd_rdy = 1'b1;
    for (int f = 0; f < 120; f++) begin
      int guard = 0;
      while (d_lvl > 4 && guard < 200) begin idlew(); guard++; end
      chk("rnd_pace", (d_lvl <= 4), 1);
      repeat ($urandom_range(0, 2)) idlew();
      enable = ($urandom_range(0, 9) != 0);
      sofw();
      len = $urandom_range(0, 10);
      for (int j = 0; j < len; j++) begin
        r = $urandom_range(0, 99);
        if (r < 10) idlew();
        else if (r < 13) begin
          rv = $urandom;
          if (r == 10) send(4'b0100, rv);
          else send(4'b0001, {rv[31:8], 8'h7C});
        end else if (r < 16) sofw();
        if (r > 90) enable = ~enable;
        rv = $urandom;
        dataw(rv);
      end
      if ($urandom_range(0, 19) != 0) eofw();
    end
    enable = 1'b1;
    eofw();
    rnd_rdy = 1'b0;
    m_tready = 1'b1;
    drain("rnd", 400);
    chk("rnd_len", mon_q.size(), mdl_q.size());
    for (int i = 0; i < mdl_q.size() && i < mon_q.size(); i++)
      chk($sformatf("rnd_w%0d", i), mon_q[i], mdl_q[i]);
    chk("rnd_fc", d_fc, m_frames);
    chk("rnd_dc", d_dc, m_drops);
    chk("rnd_ovf", d_ovf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/st_frame_buffer.md
Name: st_frame_buffer

Overview:
- Sits directly downstream of the self-trigger core's fclk output stream (dout/kout).
- Delimits K-character-framed self-trigger records and stores only complete frames in a word FIFO.
- Presents the stored frames on a valid/ready stream with tlast for the outbound link/readout logic.
- Discards truncated, oversized or overflowing frames atomically (speculative write, commit at EOF) and keeps frame and drop counters.

Parameters:
- ADDR_W, 10: FIFO depth is 2**ADDR_W words of 33 bits (32 data + last flag).
- MAX_FRAME_WORDS, 512: maximum payload words per frame; must be ≤ 2**ADDR_W.
- SOF_CHAR, 8'h3C: K28.1 start-of-frame byte.
- EOF_CHAR, 8'hDC: K28.6 end-of-frame byte.
- IDLE_CHAR, 8'hBC: K28.5 idle byte.

Ports:
- fclk  in  1  stream clock; all logic in this domain.
- reset_fclk  in  1  asynchronous, active-high reset.
- din  in  32  stream word from the self-trigger core (dout).
- kin  in  4  per-byte K flags (kout); bit0 qualifies din[7:0].
- enable  in  1  accept new frames when high.
- m_tdata  out  32  payload word.
- m_tlast  out  1  last payload word of a frame.
- m_tvalid  out  1  m_tdata/m_tlast valid.
- m_tready  in  1  consumer ready.
- frame_count  out  32  committed frames, wraps at 2**32.
- drop_count  out  16  discarded frames, saturates at 16'hFFFF.
- fifo_level  out  ADDR_W+1  committed words not yet read.
- overflow  out  1  sticky; set on any drop caused by a full FIFO; cleared only by reset.

Behaviour:
- Word classes:
  - SOF: kin==4'b0001 && din[7:0]==SOF_CHAR.
  - EOF: kin==4'b0001 && din[7:0]==EOF_CHAR.
  - IDLE: kin==4'b0001 && din[7:0]==IDLE_CHAR.
  - DATA: kin==4'b0000.
  - Any other kin/din combination is BADK.
- Reset:
  - State IDLE; read, write and commit pointers 0.
  - All outputs 0: m_tvalid=0, m_tlast=0, m_tdata=0, counters=0, fifo_level=0, overflow=0.
- FSM IDLE:
  - SOF && enable -> CAPTURE; write pointer reloads from commit pointer; payload count cleared.
  - Any other word is ignored; enable=0 ignores SOF.
- FSM CAPTURE:
  - DATA: write {0,din} at the write pointer; write pointer +1; payload count +1.
  - DATA when the FIFO is full (write pointer - read pointer == 2**ADDR_W): -> DROP; overflow<=1.
  - DATA when payload count == MAX_FRAME_WORDS: -> DROP.
  - IDLE: ignored; the frame continues.
  - EOF with payload count ≥1: set the last flag on the final written word (rewrite that RAM entry); commit pointer <= write pointer; frame_count +1; -> IDLE.
  - EOF with payload count 0: -> IDLE; nothing committed; no counter changes.
  - SOF: rewind the current frame; drop_count +1; stay in CAPTURE with a fresh frame, regardless of enable.
  - BADK: rewind; drop_count +1; -> IDLE.
  - enable falling mid-frame does not abort; the frame completes normally.
- FSM DROP:
  - Discard everything up to and including EOF; drop_count +1 on entry; -> IDLE on EOF.
  - SOF in DROP: -> CAPTURE (new frame), only if enable is high.
- Rewind: the write pointer restores to the commit pointer. Nothing past the commit pointer is ever visible at the output.
- Latency: EOF sampled at cycle N; commit pointer updated at N+1; first word of that frame has m_tvalid=1 at N+2 if the output register was empty.
- Output register:
  - Standard valid/ready. m_tdata/m_tlast hold while m_tvalid && !m_tready.
  - Transfer on m_tvalid && m_tready; the next word loads the same edge, giving 1 word/cycle.
- Pointer width: ADDR_W+1 bits with natural wrap; full/empty by MSB compare.
- fifo_level = commit pointer - read pointer, registered.
- Simultaneous commit and read in one cycle: level changes by the net amount.
- Reset asserted mid-frame or mid-readout: everything clears immediately (async); the partial frame is lost and not counted.

Optional Feature:
- Macro ST_FRAME_BUF_HWM_EN.
- When defined:
  - Adds output port fifo_hwm (ADDR_W+1): the maximum fifo_level observed since reset.
  - Updated one cycle after fifo_level changes.
  - Reset value 0.
- When undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- SOF, 4 DATA (0x11..0x44), EOF, m_tready=1 -> m_tvalid first high 2 cycles after EOF; words 0x11..0x44 output with m_tlast only on 0x44; frame_count=1.
- SOF, 3 DATA, SOF, 2 DATA (0xA,0xB), EOF -> only 0xA,0xB output; drop_count=1; frame_count=1.
- ADDR_W=4, m_tready=0, two 10-word frames -> first frame commits (fifo_level=10); second frame dropped; overflow=1; drop_count=1; after draining, exactly 10 words are read.
- MAX_FRAME_WORDS=8, frame of 9 DATA -> no output; drop_count=1; a following 2-word frame is output intact.
- SOF, EOF (no payload), then IDLE words interleaved inside a 3-word frame -> empty frame not counted; 3 words output; frame_count=1; IDLE words never stored.
- Assert reset_fclk for 1 cycle while 5 committed words are pending and m_tready=0 -> m_tvalid=0, fifo_level=0, all counters 0 immediately; the next frame is received normally.
